// File: rtl/lockstep_recovery_ctrl.sv
// Lockstep counter-pair supervisor: confirms persistent A/B mismatches, freezes and resyncs
// both counters, and escalates to a handshaked alarm when resync keeps failing.
module lockstep_recovery_ctrl #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned CONFIRM   = 2,
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned FCNT_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  cnt_a,
    input  logic [WIDTH-1:0]  cnt_b,
    output logic              cnt_en,
    output logic              resync,
    output logic [WIDTH-1:0]  resync_val,
    output logic              alarm,
    input  logic              alarm_ack,
    output logic [FCNT_W-1:0] fault_cnt,
    output logic [WIDTH-1:0]  snap_a,
    output logic [WIDTH-1:0]  snap_b
);

    localparam int unsigned CW = (CONFIRM > 1) ? $clog2(CONFIRM + 1) : 1;
    localparam int unsigned RW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int unsigned LW = WIDTH + 1;

    localparam logic [CW-1:0] CONF_LAST = CW'(CONFIRM - 1);
    localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);
    localparam logic [LW-1:0] CLEAN_LIM = {1'b1, {WIDTH{1'b0}}};
    localparam logic [FCNT_W-1:0] FCNT_MAX = {FCNT_W{1'b1}};

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_RESYNC = 2'd1;
    localparam logic [1:0] ST_VERIFY = 2'd2;
    localparam logic [1:0] ST_ALARM  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     conf_q, conf_d;
    logic [RW-1:0]     retry_q, retry_d;
    logic [LW-1:0]     clean_q, clean_d;
    logic [FCNT_W-1:0] fault_cnt_q, fault_cnt_d;
    logic [WIDTH-1:0]  snap_a_q, snap_a_d;
    logic [WIDTH-1:0]  snap_b_q, snap_b_d;
    logic [WIDTH-1:0]  resync_val_q, resync_val_d;
    logic              cnt_en_q, cnt_en_d;
    logic              resync_q, resync_d;
    logic              alarm_q, alarm_d;
    logic              mismatch;

    assign mismatch = (cnt_a != cnt_b);

    always_comb begin
        state_d      = state_q;
        conf_d       = conf_q;
        retry_d      = retry_q;
        clean_d      = clean_q;
        fault_cnt_d  = fault_cnt_q;
        snap_a_d     = snap_a_q;
        snap_b_d     = snap_b_q;
        resync_val_d = resync_val_q;

        case (state_q)
            ST_RUN: begin
                if (mismatch) begin
                    clean_d = '0;
                    if (conf_q == CONF_LAST) begin
                        conf_d       = '0;
                        snap_a_d     = cnt_a;
                        snap_b_d     = cnt_b;
                        resync_val_d = cnt_a;
                        if (fault_cnt_q != FCNT_MAX) begin
                            fault_cnt_d = fault_cnt_q + 1'b1;
                        end
                        state_d = ST_RESYNC;
                    end else begin
                        conf_d = conf_q + 1'b1;
                    end
                end else begin
                    conf_d = '0;
                    if (clean_q != CLEAN_LIM) begin
                        clean_d = clean_q + 1'b1;
                    end
                    // A long enough clean run restores the full retry budget.
                    if (clean_d == CLEAN_LIM) begin
                        retry_d = '0;
                    end
                end
            end
            ST_RESYNC: begin
                if (retry_q != RETRY_LIM) begin
                    retry_d = retry_q + 1'b1;
                end
                state_d = ST_VERIFY;
            end
            ST_VERIFY: begin
                if (!mismatch && (cnt_a == resync_val_q)) begin
                    state_d = ST_RUN;
                end else if (retry_q == RETRY_LIM) begin
                    state_d = ST_ALARM;
                end else begin
                    state_d = ST_RESYNC;
                end
            end
            ST_ALARM: begin
                if (alarm_ack) begin
                    retry_d = '0;
                    clean_d = '0;
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase

        cnt_en_d = (state_d == ST_RUN);
        resync_d = (state_d == ST_RESYNC);
        alarm_d  = (state_d == ST_ALARM);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_RUN;
            conf_q       <= '0;
            retry_q      <= '0;
            clean_q      <= '0;
            fault_cnt_q  <= '0;
            snap_a_q     <= '0;
            snap_b_q     <= '0;
            resync_val_q <= '0;
            cnt_en_q     <= 1'b0;
            resync_q     <= 1'b0;
            alarm_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            conf_q       <= conf_d;
            retry_q      <= retry_d;
            clean_q      <= clean_d;
            fault_cnt_q  <= fault_cnt_d;
            snap_a_q     <= snap_a_d;
            snap_b_q     <= snap_b_d;
            resync_val_q <= resync_val_d;
            cnt_en_q     <= cnt_en_d;
            resync_q     <= resync_d;
            alarm_q      <= alarm_d;
        end
    end

    assign cnt_en     = cnt_en_q;
    assign resync     = resync_q;
    assign resync_val = resync_val_q;
    assign alarm      = alarm_q;
    assign fault_cnt  = fault_cnt_q;
    assign snap_a     = snap_a_q;
    assign snap_b     = snap_b_q;

endmodule

// File: tb/tb_lockstep_recovery_ctrl.sv
// Directed bench for lockstep_recovery_ctrl: per-cycle vector table plus a fault-counter
// saturation sequence on a second instance with a 2-bit fault counter.
module tb_lockstep_recovery_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] cnt_a = '0;
    logic [3:0] cnt_b = '0;
    logic       alarm_ack = 1'b0;

    logic       cnt_en, resync, alarm;
    logic [3:0] resync_val, snap_a, snap_b;
    logic [7:0] fault_cnt;

    logic       cnt_en2, resync2, alarm2;
    logic [3:0] resync_val2, snap_a2, snap_b2;
    logic [1:0] fault_cnt2;

    always #5 clk = ~clk;

    lockstep_recovery_ctrl #(.WIDTH(4), .CONFIRM(2), .MAX_RETRY(3), .FCNT_W(8)) dut (
        .clk(clk), .reset(reset), .cnt_a(cnt_a), .cnt_b(cnt_b), .cnt_en(cnt_en),
        .resync(resync), .resync_val(resync_val), .alarm(alarm), .alarm_ack(alarm_ack),
        .fault_cnt(fault_cnt), .snap_a(snap_a), .snap_b(snap_b)
    );

    lockstep_recovery_ctrl #(.WIDTH(4), .CONFIRM(2), .MAX_RETRY(3), .FCNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .cnt_a(cnt_a), .cnt_b(cnt_b), .cnt_en(cnt_en2),
        .resync(resync2), .resync_val(resync_val2), .alarm(alarm2), .alarm_ack(alarm_ack),
        .fault_cnt(fault_cnt2), .snap_a(snap_a2), .snap_b(snap_b2)
    );

    typedef struct packed {
        logic       rst;
        logic [3:0] a;
        logic [3:0] b;
        logic       ack;
        logic       en;
        logic       rs;
        logic [3:0] rv;
        logic       al;
        logic [7:0] fc;
        logic [3:0] sa;
        logic [3:0] sb;
    } vec_t;

    vec_t vecs [0:199];
    int   nvec = 0;
    int   checks = 0;
    int   failures = 0;

    task automatic add(input logic rst, input logic [3:0] a, input logic [3:0] b,
                       input logic ack, input logic en, input logic rs, input logic [3:0] rv,
                       input logic al, input logic [7:0] fc, input logic [3:0] sa,
                       input logic [3:0] sb);
        vecs[nvec] = '{rst: rst, a: a, b: b, ack: ack, en: en, rs: rs, rv: rv, al: al,
                       fc: fc, sa: sa, sb: sb};
        nvec++;
    endtask

    task automatic check(input string name, input int row, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d actual=%0d expected=%0d", name, row, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic [3:0] a, input logic [3:0] b,
                        input logic ack);
        @(negedge clk);
        reset     = rst;
        cnt_a     = a;
        cnt_b     = b;
        alarm_ack = ack;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Matched stepping; also fills the clean window
        for (int i = 0; i < 16; i++) add(1, 4'(i), 4'(i), 0, 1, 0, 0, 0, 0, 0, 0);
        // Transient mismatches (ack outside ALARM ignored)
        add(1, 5, 7, 1, 1, 0, 0, 0, 0, 0, 0);
        add(1, 8, 8, 0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 5, 7, 0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 8, 8, 1, 1, 0, 0, 0, 0, 0, 0);
        // Persistent fault; first verify sees equal counters but wrong value
        add(1, 9, 3, 0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 9, 3, 0, 0, 1, 9, 0, 1, 9, 3);
        add(1, 9, 3, 0, 0, 0, 9, 0, 1, 9, 3);
        add(1, 5, 5, 0, 0, 1, 9, 0, 1, 9, 3);
        add(1, 5, 5, 0, 0, 0, 9, 0, 1, 9, 3);
        add(1, 9, 9, 0, 1, 0, 9, 0, 1, 9, 3);
        // 16 clean cycles restore the retry budget
        for (int j = 0; j < 16; j++) add(1, 4'(j), 4'(j), 0, 1, 0, 9, 0, 1, 9, 3);
        // Stuck counter B: three resyncs then alarm; ack with mismatch returns to RUN
        add(1, 4, 3, 0, 1, 0, 9, 0, 1, 9, 3);
        add(1, 4, 3, 0, 0, 1, 4, 0, 2, 4, 3);
        add(1, 4, 3, 0, 0, 0, 4, 0, 2, 4, 3);
        add(1, 4, 3, 0, 0, 1, 4, 0, 2, 4, 3);
        add(1, 4, 3, 0, 0, 0, 4, 0, 2, 4, 3);
        add(1, 4, 3, 0, 0, 1, 4, 0, 2, 4, 3);
        add(1, 4, 3, 0, 0, 0, 4, 0, 2, 4, 3);
        add(1, 4, 3, 0, 0, 0, 4, 1, 2, 4, 3);
        add(1, 4, 3, 0, 0, 0, 4, 1, 2, 4, 3);
        add(1, 4, 3, 1, 1, 0, 4, 0, 2, 4, 3);
        add(1, 4, 3, 0, 1, 0, 4, 0, 2, 4, 3);
        add(1, 4, 4, 0, 1, 0, 4, 0, 2, 4, 3);
        // Back into ALARM, then reset there
        add(1, 4, 3, 0, 1, 0, 4, 0, 2, 4, 3);
        add(1, 4, 3, 0, 0, 1, 4, 0, 3, 4, 3);
        add(1, 4, 3, 0, 0, 0, 4, 0, 3, 4, 3);
        add(1, 4, 3, 0, 0, 1, 4, 0, 3, 4, 3);
        add(1, 4, 3, 0, 0, 0, 4, 0, 3, 4, 3);
        add(1, 4, 3, 0, 0, 1, 4, 0, 3, 4, 3);
        add(1, 4, 3, 0, 0, 0, 4, 0, 3, 4, 3);
        add(1, 4, 3, 0, 0, 0, 4, 1, 3, 4, 3);
        add(0, 4, 3, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        // Reset during RESYNC
        add(1, 2, 6, 0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 2, 6, 0, 0, 1, 2, 0, 1, 2, 6);
        add(0, 2, 6, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);

        for (int k = 0; k < nvec; k++) begin
            step(vecs[k].rst, vecs[k].a, vecs[k].b, vecs[k].ack);
            check("cnt_en", k, 32'(cnt_en), 32'(vecs[k].en));
            check("resync", k, 32'(resync), 32'(vecs[k].rs));
            check("resync_val", k, 32'(resync_val), 32'(vecs[k].rv));
            check("alarm", k, 32'(alarm), 32'(vecs[k].al));
            check("fault_cnt", k, 32'(fault_cnt), 32'(vecs[k].fc));
            check("snap_a", k, 32'(snap_a), 32'(vecs[k].sa));
            check("snap_b", k, 32'(snap_b), 32'(vecs[k].sb));
        end

        // Five recovered faults: 8-bit counter reaches 5, 2-bit counter sticks at 3
        for (int f = 1; f <= 5; f++) begin
            step(1, 1, 2, 0);
            check("sat_conf_en", 1000 + f, 32'(cnt_en), 32'd1);
            step(1, 1, 2, 0);
            check("sat_resync", 1000 + f, 32'(resync), 32'd1);
            check("sat_fc8", 1000 + f, 32'(fault_cnt), 32'(f));
            check("sat_fc2", 1000 + f, 32'(fault_cnt2), (f > 3) ? 32'd3 : 32'(f));
            step(1, 1, 2, 0);
            step(1, 1, 1, 0);
            check("sat_recover_en", 1000 + f, 32'(cnt_en), 32'd1);
            check("sat_alarm", 1000 + f, 32'(alarm), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
